// File: rtl/led_bounce.sv
// Bidirectional one-hot LED scanner: the lit bit walks 0 -> MSB, dwells,
// walks back to 0, dwells, and repeats. A free-running prescaler provides
// the step enable; everything runs on the single system clock.
module led_bounce #(
  parameter int unsigned COUNTER_BITS = 21,
  parameter int unsigned LED_BITS     = 16,
  parameter int unsigned DWELL_TICKS  = 4
) (
  input  logic                clk,
  input  logic                btnC,
  input  logic                pause,
  output logic [LED_BITS-1:0] led,
  output logic                dir,
  output logic                end_pulse
);

  localparam int unsigned DwellW = (DWELL_TICKS == 0) ? 1 : $clog2(DWELL_TICKS + 1);
  // Dwell states are unreachable when DWELL_TICKS is 0, so the value is moot there.
  localparam logic [DwellW-1:0] DwellLast =
      (DWELL_TICKS == 0) ? '0 : DwellW'(DWELL_TICKS - 1);
  localparam bit NoDwell = (DWELL_TICKS == 0);

  typedef enum logic [1:0] {StLeft, StDwellHi, StRight, StDwellLo} state_e;

  logic [COUNTER_BITS-1:0] presc_q, presc_d;
  logic [LED_BITS-1:0]     led_q, led_d;
  logic [DwellW-1:0]       dwell_q, dwell_d;
  state_e                  state_q, state_d;
  logic                    dir_q, dir_d;
  logic                    end_q, end_d;
  logic                    tick;

  // A paused cycle neither advances the prescaler nor produces a tick.
  assign tick    = (&presc_q) & ~pause;
  assign presc_d = pause ? presc_q : presc_q + COUNTER_BITS'(1);

  // Next-state and output decode; state moves only on a tick.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    end_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        StLeft: begin
          led_d = led_q << 1;
          // Arriving at the MSB when the bit just below it is the lit one.
          if (led_q[LED_BITS-2]) begin
            end_d   = 1'b1;
            dwell_d = '0;
            if (NoDwell) begin
              state_d = StRight;
              dir_d   = 1'b0;
            end else begin
              state_d = StDwellHi;
            end
          end
        end
        StDwellHi: begin
          if (dwell_q == DwellLast) begin
            state_d = StRight;
            dir_d   = 1'b0;
          end else begin
            dwell_d = dwell_q + DwellW'(1);
          end
        end
        StRight: begin
          led_d = led_q >> 1;
          if (led_q[1]) begin
            end_d   = 1'b1;
            dwell_d = '0;
            if (NoDwell) begin
              state_d = StLeft;
              dir_d   = 1'b1;
            end else begin
              state_d = StDwellLo;
            end
          end
        end
        StDwellLo: begin
          if (dwell_q == DwellLast) begin
            state_d = StLeft;
            dir_d   = 1'b1;
          end else begin
            dwell_d = dwell_q + DwellW'(1);
          end
        end
        default: begin
          state_d = StLeft;
          led_d   = LED_BITS'(1);
          dir_d   = 1'b1;
          dwell_d = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset that overrides pause and tick.
  always_ff @(posedge clk) begin
    if (btnC) begin
      presc_q <= '0;
      led_q   <= LED_BITS'(1);
      dwell_q <= '0;
      state_q <= StLeft;
      dir_q   <= 1'b1;
      end_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      led_q   <= led_d;
      dwell_q <= dwell_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      end_q   <= end_d;
    end
  end

  assign led       = led_q;
  assign dir       = dir_q;
  assign end_pulse = end_q;

endmodule

// File: tb/tb_led_bounce.sv
// Bench for led_bounce: edge-indexed vector tables on small configurations,
// hand-written pause/reset sequences, and a randomized run against a
// period-table reference model.
module tb_led_bounce;

  logic        clk = 1'b0;
  logic        a_btn, a_pause, c_btn, c_pause;
  logic [3:0]  a_led, b_led;
  logic        a_dir, a_end, b_dir, b_end;
  logic [15:0] c_led, d_led;
  logic        c_dir, c_end, d_dir, d_end;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_bounce #(.COUNTER_BITS(2), .LED_BITS(4), .DWELL_TICKS(2)) u_a (
    .clk(clk), .btnC(a_btn), .pause(a_pause), .led(a_led), .dir(a_dir), .end_pulse(a_end)
  );
  led_bounce #(.COUNTER_BITS(2), .LED_BITS(4), .DWELL_TICKS(0)) u_b (
    .clk(clk), .btnC(a_btn), .pause(a_pause), .led(b_led), .dir(b_dir), .end_pulse(b_end)
  );
  led_bounce #(.COUNTER_BITS(3), .LED_BITS(16), .DWELL_TICKS(3)) u_c (
    .clk(clk), .btnC(c_btn), .pause(c_pause), .led(c_led), .dir(c_dir), .end_pulse(c_end)
  );
  led_bounce u_d (
    .clk(clk), .btnC(c_btn), .pause(c_pause), .led(d_led), .dir(d_dir), .end_pulse(d_end)
  );

  typedef struct {
    int         e;
    bit         sel;
    logic [3:0] led;
    logic       dir;
    logic       endp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_btn = 1'b1;
    step();
    a_btn = 1'b0;
  endtask

  // Reference model for u_c: one period of (position, dir, arrival) per tick.
  localparam int N = 16;
  localparam int D = 3;
  localparam int P = 2 * (N - 1) + 2 * D;
  int pat_pos[P];
  bit pat_dir[P];
  bit pat_end[P];

  initial begin
    int np;
    int presc, ticks, idx;
    bit mend;
    logic [15:0] el;
    logic        ed;

    a_btn = 1'b1; a_pause = 1'b0; c_btn = 1'b1; c_pause = 1'b0;
    step(); step();

    // Sampled just after edge e counted from reset release.
    tbl.push_back('{3,  0, 4'b0001, 1, 0});
    tbl.push_back('{4,  0, 4'b0010, 1, 0});
    tbl.push_back('{8,  0, 4'b0100, 1, 0});
    tbl.push_back('{11, 0, 4'b0100, 1, 0});
    tbl.push_back('{12, 0, 4'b1000, 1, 1});
    tbl.push_back('{13, 0, 4'b1000, 1, 0});
    tbl.push_back('{16, 0, 4'b1000, 1, 0});
    tbl.push_back('{20, 0, 4'b1000, 0, 0});
    tbl.push_back('{24, 0, 4'b0100, 0, 0});
    tbl.push_back('{32, 0, 4'b0001, 0, 1});
    tbl.push_back('{33, 0, 4'b0001, 0, 0});
    tbl.push_back('{36, 0, 4'b0001, 0, 0});
    tbl.push_back('{40, 0, 4'b0001, 1, 0});
    tbl.push_back('{44, 0, 4'b0010, 1, 0});
    tbl.push_back('{52, 0, 4'b1000, 1, 1});
    tbl.push_back('{72, 0, 4'b0001, 0, 1});
    tbl.push_back('{84, 0, 4'b0010, 1, 0});
    tbl.push_back('{4,  1, 4'b0010, 1, 0});
    tbl.push_back('{8,  1, 4'b0100, 1, 0});
    tbl.push_back('{12, 1, 4'b1000, 0, 1});
    tbl.push_back('{13, 1, 4'b1000, 0, 0});
    tbl.push_back('{16, 1, 4'b0100, 0, 0});
    tbl.push_back('{20, 1, 4'b0010, 0, 0});
    tbl.push_back('{24, 1, 4'b0001, 1, 1});
    tbl.push_back('{28, 1, 4'b0010, 1, 0});
    tbl.push_back('{48, 1, 4'b0001, 1, 1});
    tbl.push_back('{52, 1, 4'b0010, 1, 0});

    reset_a();
    chk("reset led", a_led, 4'b0001);
    chk("reset dir", a_dir, 1'b1);
    chk("reset end", a_end, 1'b0);
    for (int e = 1; e <= 84; e++) begin
      step();
      for (int i = 0; i < tbl.size(); i++) begin
        if (tbl[i].e == e) begin
          chk($sformatf("tbl[%0d] led", i), tbl[i].sel ? b_led : a_led, tbl[i].led);
          chk($sformatf("tbl[%0d] dir", i), tbl[i].sel ? b_dir : a_dir, tbl[i].dir);
          chk($sformatf("tbl[%0d] end", i), tbl[i].sel ? b_end : a_end, tbl[i].endp);
        end
      end
    end

    // Pause for 10 cycles starting in the cycle the prescaler is 3.
    reset_a();
    for (int e = 1; e <= 3; e++) step();
    a_pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pause led", a_led, 4'b0001);
      chk("pause end", a_end, 1'b0);
    end
    a_pause = 1'b0;
    step();
    chk("pause release step", a_led, 4'b0010);
    for (int e = 15; e <= 22; e++) begin
      step();
      if (e == 21) chk("pause delayed 0100", a_led, 4'b0100);
    end
    chk("pause delayed 1000", a_led, 4'b1000);
    chk("pause delayed end", a_end, 1'b1);

    // Reset during DWELL_HI.
    reset_a();
    for (int e = 1; e <= 14; e++) step();
    chk("dwell led", a_led, 4'b1000);
    a_btn = 1'b1;
    step();
    a_btn = 1'b0;
    chk("midreset led", a_led, 4'b0001);
    chk("midreset dir", a_dir, 1'b1);
    chk("midreset end", a_end, 1'b0);
    for (int e = 1; e <= 3; e++) step();
    chk("midreset hold", a_led, 4'b0001);
    step();
    chk("midreset first step", a_led, 4'b0010);

    // Reset on the exact tick edge wins.
    reset_a();
    for (int e = 1; e <= 3; e++) step();
    a_btn = 1'b1;
    step();
    a_btn = 1'b0;
    chk("reset vs tick led", a_led, 4'b0001);
    chk("reset vs tick end", a_end, 1'b0);

    // Build one period of the sweep for the random run.
    np = 0;
    for (int i = 1; i <= N - 1; i++) begin
      pat_pos[np] = i; pat_dir[np] = !(i == N - 1 && D == 0); pat_end[np] = (i == N - 1); np++;
    end
    for (int i = 1; i <= D; i++) begin
      pat_pos[np] = N - 1; pat_dir[np] = (i != D); pat_end[np] = 1'b0; np++;
    end
    for (int i = N - 2; i >= 0; i--) begin
      pat_pos[np] = i; pat_dir[np] = (i == 0 && D == 0); pat_end[np] = (i == 0); np++;
    end
    for (int i = 1; i <= D; i++) begin
      pat_pos[np] = 0; pat_dir[np] = (i == D); pat_end[np] = 1'b0; np++;
    end

    presc = 0; ticks = 0; mend = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      c_btn   = ($urandom_range(0, 299) == 0);
      c_pause = ($urandom_range(0, 3) == 0);
      step();
      if (c_btn) begin
        presc = 0; ticks = 0; mend = 1'b0;
      end else if (c_pause) begin
        mend = 1'b0;
      end else if (presc == 7) begin
        presc = 0; ticks++; mend = pat_end[(ticks - 1) % P];
      end else begin
        presc++; mend = 1'b0;
      end
      if (ticks == 0) begin
        el = 16'h0001; ed = 1'b1;
      end else begin
        idx = (ticks - 1) % P;
        el = 16'(1) << pat_pos[idx];
        ed = pat_dir[idx];
      end
      chk("rnd led", c_led, el);
      chk("rnd dir", c_dir, ed);
      chk("rnd end", c_end, mend);
      chk("onehot c", $onehot(c_led), 1);
      chk("onehot d", $onehot(d_led), 1);
    end
    // Default prescaler is far too slow to step within this run.
    chk("default led", d_led, 16'h0001);
    chk("default dir", d_dir, 1'b1);
    chk("default end", d_end, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
